// File: rtl/pattern_bank_if.sv
// Bus bundle for pattern_bank: serial frame port, random-access field port and the
// full-buffer view. The master side drives requests, the slave side is the bank.
interface pattern_bank_if #(
  parameter int NUM_BUFS  = 8,
  parameter int BUF_SIZE  = 22,
  parameter int BUF_WIDTH = 8
);
  localparam int AW    = $clog2(NUM_BUFS);
  localparam int PW    = $clog2(BUF_SIZE);
  localparam int FRAME = BUF_SIZE * BUF_WIDTH;

  logic                 ssel;
  logic                 sstrobe;
  logic                 sin;
  logic [AW-1:0]        saddr;
  logic                 sout;
  logic                 sbusy;
  logic                 serr;
  logic                 commit_done;
  logic [AW-1:0]        field_bufp;
  logic [PW-1:0]        field_ptr;
  logic [BUF_WIDTH-1:0] field_byte;
  logic [BUF_WIDTH-1:0] field_in;
  logic                 field_write;
  logic                 wr_conflict;
  logic [AW-1:0]        cur_sel;
  logic [FRAME-1:0]     cur_buf;

  modport master (
    output ssel, sstrobe, sin, saddr, field_bufp, field_ptr, field_in, field_write, cur_sel,
    input  sout, sbusy, serr, commit_done, field_byte, wr_conflict, cur_buf
  );
  modport slave (
    input  ssel, sstrobe, sin, saddr, field_bufp, field_ptr, field_in, field_write, cur_sel,
    output sout, sbusy, serr, commit_done, field_byte, wr_conflict, cur_buf
  );
endinterface

// File: rtl/pattern_bank.sv
// Bank of NUM_BUFS pattern buffers with atomic serial frame load/readback through a
// shadow register, random-access field read/write and a combinational full-buffer view.
module pattern_bank #(
  parameter int NUM_BUFS  = 8,
  parameter int BUF_SIZE  = 22,
  parameter int BUF_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  pattern_bank_if.slave  bus
);
  localparam int AW    = $clog2(NUM_BUFS);
  localparam int PW    = $clog2(BUF_SIZE);
  localparam int FRAME = BUF_SIZE * BUF_WIDTH;
  localparam int CW    = $clog2(FRAME + 2);

  localparam logic [AW:0]   NB       = (AW+1)'(NUM_BUFS);
  localparam logic [PW:0]   NE       = (PW+1)'(BUF_SIZE);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME);
  localparam logic [CW-1:0] CNT_OVR  = CW'(FRAME + 1);

  // Packed so a buffer flattens with entry BUF_SIZE-1 in the top bits, matching the shadow.
  typedef logic [BUF_SIZE-1:0][BUF_WIDTH-1:0] buf_t;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                   state_q, state_d;
  buf_t [NUM_BUFS-1:0]      mem_q, mem_d;
  logic [FRAME-1:0]         shadow_q, shadow_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [AW-1:0]            tgt_q, tgt_d;
  logic                     tgt_ok_q, tgt_ok_d;
  logic                     serr_q, serr_d;
  logic                     sbusy_q, sbusy_d;
  logic                     commit_done_q, commit_done_d;
  logic                     wr_conflict_q, wr_conflict_d;
  logic [BUF_WIDTH-1:0]     field_byte_q, field_byte_d;
  logic                     fld_ok, fld_hit, cur_ok;

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    shadow_d      = shadow_q;
    cnt_d         = cnt_q;
    tgt_d         = tgt_q;
    tgt_ok_d      = tgt_ok_q;
    serr_d        = serr_q;
    fld_ok        = ({1'b0, bus.field_bufp} < NB) && ({1'b0, bus.field_ptr} < NE);
    fld_hit       = (state_q == COMMIT) && (bus.field_bufp == tgt_q);
    cur_ok        = {1'b0, bus.cur_sel} < NB;

    case (state_q)
      IDLE: if (bus.ssel) begin
        state_d  = SHIFT;
        tgt_d    = bus.saddr;
        tgt_ok_d = {1'b0, bus.saddr} < NB;
        shadow_d = tgt_ok_d ? mem_q[bus.saddr] : '0;
        cnt_d    = '0;
        serr_d   = 1'b0;
      end
      SHIFT: begin
        if (bus.ssel) begin
          if (bus.sstrobe) begin
            shadow_d = {shadow_q[FRAME-2:0], bus.sin};
            if (cnt_q != CNT_OVR) cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q == CNT_FULL && tgt_ok_q) begin
          state_d = COMMIT;
        end else begin
          state_d = IDLE;
          serr_d  = 1'b1;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The commit owns the target buffer for its one cycle; a colliding field write is dropped.
    if (bus.field_write && fld_ok && !fld_hit)
      mem_d[bus.field_bufp][bus.field_ptr] = bus.field_in;
    if (state_q == COMMIT)
      mem_d[tgt_q] = shadow_q;

    wr_conflict_d = bus.field_write && fld_ok && fld_hit;
    commit_done_d = (state_d == COMMIT);
    sbusy_d       = (state_d != IDLE);
    field_byte_d  = fld_ok ? mem_q[bus.field_bufp][bus.field_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_q         <= '0;
      shadow_q      <= '0;
      cnt_q         <= '0;
      tgt_q         <= '0;
      tgt_ok_q      <= 1'b0;
      serr_q        <= 1'b0;
      sbusy_q       <= 1'b0;
      commit_done_q <= 1'b0;
      wr_conflict_q <= 1'b0;
      field_byte_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      shadow_q      <= shadow_d;
      cnt_q         <= cnt_d;
      tgt_q         <= tgt_d;
      tgt_ok_q      <= tgt_ok_d;
      serr_q        <= serr_d;
      sbusy_q       <= sbusy_d;
      commit_done_q <= commit_done_d;
      wr_conflict_q <= wr_conflict_d;
      field_byte_q  <= field_byte_d;
    end
  end

  assign bus.sout        = (state_q == SHIFT) & shadow_q[FRAME-1];
  assign bus.sbusy       = sbusy_q;
  assign bus.serr        = serr_q;
  assign bus.commit_done = commit_done_q;
  assign bus.wr_conflict = wr_conflict_q;
  assign bus.field_byte  = field_byte_q;
  assign bus.cur_buf     = cur_ok ? mem_q[bus.cur_sel] : '0;
endmodule
